mem_bus_arbiter: RTL and testbench

//  - Shares one single-port word memory (SIZE words, registered read) between two valid/ready masters.
//  - m0: picorv32 native bus (CPU). m1: secondary master (loader/debug/DMA), same protocol without instr.
//  - Generates the per-master mem_ready that the CPU otherwise has tied high.
//  - Sequences each access: arbitrate, strobe, wait read latency, respond.

---
 rtl/mem_bus_arbiter.sv | 151 +++++++++++++++
 tb/tb_mem_bus_arbiter.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_bus_arbiter.sv
// Two-master valid/ready arbiter in front of one single-port word memory with registered read.
// Define MEM_ARB_RR_EN for round-robin arbitration; otherwise m0 has fixed priority.
`timescale 1ns/1ps
module mem_bus_arbiter #(
   parameter int unsigned SIZE   = 1024,
   parameter int unsigned RD_LAT = 1
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        m0_valid,
   input  logic        m0_instr,
   input  logic [31:0] m0_addr,
   input  logic [31:0] m0_wdata,
   input  logic [3:0]  m0_wstrb,
   output logic        m0_ready,
   output logic [31:0] m0_rdata,
   input  logic        m1_valid,
   input  logic [31:0] m1_addr,
   input  logic [31:0] m1_wdata,
   input  logic [3:0]  m1_wstrb,
   output logic        m1_ready,
   output logic [31:0] m1_rdata,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   output logic [3:0]  mem_wmask,
   output logic        mem_rstrb,
   input  logic [31:0] mem_rdata,
   output logic        oor_err
);

   localparam logic [31:0] SIZE_W = 32'(SIZE);
   localparam logic [1:0]  LAT_M1 = 2'(RD_LAT - 1);

   typedef enum logic [1:0] {IDLE, STROBE, WAIT} state_t;

   state_t      state;
   logic        gnt;
   logic [3:0]  cur_wstrb;
   logic        cur_oor;
   logic [1:0]  cnt;
   logic        rd_ack;

   logic        sel;
   logic [31:0] sel_addr;
   logic [31:0] sel_wdata;
   logic [3:0]  sel_wstrb;
   logic        sel_oor;

   logic        unused_ok;
   assign unused_ok = m0_instr;

`ifdef MEM_ARB_RR_EN
   logic last_gnt;
   // last_gnt resets to 1 so that m0 wins the first simultaneous request
   always_comb begin
      sel = m1_valid & (~m0_valid | ~last_gnt);
   end
`else
   always_comb begin
      sel = m1_valid & ~m0_valid;
   end
`endif

   always_comb begin
      sel_addr  = sel ? m1_addr  : m0_addr;
      sel_wdata = sel ? m1_wdata : m0_wdata;
      sel_wstrb = sel ? m1_wstrb : m0_wstrb;
      sel_oor   = ({2'b00, sel_addr[31:2]} >= SIZE_W);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= IDLE;
         gnt       <= 1'b0;
         cur_wstrb <= '0;
         cur_oor   <= 1'b0;
         cnt       <= '0;
         rd_ack    <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= '0;
         mem_wmask <= '0;
         mem_rstrb <= 1'b0;
         m0_ready  <= 1'b0;
         m1_ready  <= 1'b0;
         oor_err   <= 1'b0;
`ifdef MEM_ARB_RR_EN
         last_gnt  <= 1'b1;
`endif
      end else begin
         mem_wmask <= '0;
         mem_rstrb <= 1'b0;
         m0_ready  <= 1'b0;
         m1_ready  <= 1'b0;
         oor_err   <= 1'b0;
         rd_ack    <= 1'b0;
         case (state)
            IDLE: begin
               if (m0_valid || m1_valid) begin
                  gnt       <= sel;
                  mem_addr  <= sel_addr;
                  mem_wdata <= sel_wdata;
                  cur_wstrb <= sel_wstrb;
                  cur_oor   <= sel_oor;
                  if (!sel_oor) begin
                     if (sel_wstrb != 4'b0000) mem_wmask <= sel_wstrb;
                     else                      mem_rstrb <= 1'b1;
                  end
`ifdef MEM_ARB_RR_EN
                  last_gnt  <= sel;
`endif
                  state     <= STROBE;
               end
            end
            STROBE: begin
               state <= WAIT;
               if (cur_oor || cur_wstrb != 4'b0000) begin
                  m0_ready <= ~gnt;
                  m1_ready <= gnt;
                  oor_err  <= cur_oor;
                  cnt      <= '0;
               end else begin
                  cnt <= LAT_M1;
                  if (LAT_M1 == 2'd0) begin
                     m0_ready <= ~gnt;
                     m1_ready <= gnt;
                     rd_ack   <= 1'b1;
                  end
               end
            end
            WAIT: begin
               // the ready cycle itself is spent in WAIT, so IDLE never sees a stale valid
               if (m0_ready || m1_ready) begin
                  state <= IDLE;
               end else begin
                  cnt <= cnt - 2'd1;
                  if (cnt == 2'd1) begin
                     m0_ready <= ~gnt;
                     m1_ready <= gnt;
                     rd_ack   <= 1'b1;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign m0_rdata = (m0_ready && rd_ack) ? mem_rdata : '0;
   assign m1_rdata = (m1_ready && rd_ack) ? mem_rdata : '0;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench for mem_bus_arbiter: RD_LAT=1 instance for most cases, RD_LAT=3 instance for latency.
`timescale 1ns/1ps
module tb_mem_bus_arbiter;

   logic clk = 1'b0;
   logic rst;
   logic init_mem;
   always #5 clk = ~clk;

   logic        m0_valid, m0_instr, m0_ready, m1_valid, m1_ready;
   logic [31:0] m0_addr, m0_wdata, m0_rdata, m1_addr, m1_wdata, m1_rdata;
   logic [3:0]  m0_wstrb, m1_wstrb;
   logic [31:0] mem_addr, mem_wdata, mem_rdata;
   logic [3:0]  mem_wmask;
   logic        mem_rstrb, oor_err;

   logic        b_m0_valid, b_m0_instr, b_m0_ready, b_m1_valid, b_m1_ready;
   logic [31:0] b_m0_addr, b_m0_wdata, b_m0_rdata, b_m1_addr, b_m1_wdata, b_m1_rdata;
   logic [3:0]  b_m0_wstrb, b_m1_wstrb;
   logic [31:0] b_mem_addr, b_mem_wdata, b_mem_rdata;
   logic [3:0]  b_mem_wmask;
   logic        b_mem_rstrb, b_oor_err;

   mem_bus_arbiter #(.SIZE(1024), .RD_LAT(1)) dut_a (
      .clk(clk), .reset(rst),
      .m0_valid(m0_valid), .m0_instr(m0_instr), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
      .m0_wstrb(m0_wstrb), .m0_ready(m0_ready), .m0_rdata(m0_rdata),
      .m1_valid(m1_valid), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
      .m1_wstrb(m1_wstrb), .m1_ready(m1_ready), .m1_rdata(m1_rdata),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wmask(mem_wmask),
      .mem_rstrb(mem_rstrb), .mem_rdata(mem_rdata), .oor_err(oor_err));

   mem_bus_arbiter #(.SIZE(1024), .RD_LAT(3)) dut_b (
      .clk(clk), .reset(rst),
      .m0_valid(b_m0_valid), .m0_instr(b_m0_instr), .m0_addr(b_m0_addr), .m0_wdata(b_m0_wdata),
      .m0_wstrb(b_m0_wstrb), .m0_ready(b_m0_ready), .m0_rdata(b_m0_rdata),
      .m1_valid(b_m1_valid), .m1_addr(b_m1_addr), .m1_wdata(b_m1_wdata),
      .m1_wstrb(b_m1_wstrb), .m1_ready(b_m1_ready), .m1_rdata(b_m1_rdata),
      .mem_addr(b_mem_addr), .mem_wdata(b_mem_wdata), .mem_wmask(b_mem_wmask),
      .mem_rstrb(b_mem_rstrb), .mem_rdata(b_mem_rdata), .oor_err(b_oor_err));

   function automatic logic [31:0] init_word(input int unsigned i);
      return 32'hC0DE_0000 | 32'(i);
   endfunction

   // Memory models: registered read, latency 1 (a) and 3 (b)
   logic [31:0] mem_a [0:1023];
   logic [31:0] mem_b [0:1023];
   logic [31:0] a_rd, b_p1, b_p2, b_p3;
   assign mem_rdata   = a_rd;
   assign b_mem_rdata = b_p3;

   always @(posedge clk) begin
      if (init_mem) begin
         for (int i = 0; i < 1024; i++) begin
            mem_a[i] <= init_word(i);
            mem_b[i] <= init_word(i);
         end
      end else begin
         if (mem_wmask != 4'b0000 && mem_addr[31:12] == 20'd0)
            for (int b = 0; b < 4; b++)
               if (mem_wmask[b]) mem_a[mem_addr[11:2]][8*b +: 8] <= mem_wdata[8*b +: 8];
         if (b_mem_wmask != 4'b0000 && b_mem_addr[31:12] == 20'd0)
            for (int b = 0; b < 4; b++)
               if (b_mem_wmask[b]) mem_b[b_mem_addr[11:2]][8*b +: 8] <= b_mem_wdata[8*b +: 8];
      end
      if (mem_rstrb) a_rd <= mem_a[mem_addr[11:2]];
      if (b_mem_rstrb) b_p1 <= mem_b[b_mem_addr[11:2]];
      b_p2 <= b_p1;
      b_p3 <= b_p2;
   end

   int nvec = 0;
   int nerr = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      nvec++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s: got %h, want %h", name, act, exp);
      end
   endtask

   typedef struct {
      logic        mst;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [3:0]  wstrb;
      logic        drop;
      logic [31:0] exp_rdata;
      logic        exp_oor;
      logic [3:0]  exp_mask;
      logic        exp_rstrb;
      int          exp_lat;
   } vec_t;

   vec_t vt[13];

   task automatic drive(input logic mst, input logic v, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [3:0] wstrb);
      if (mst) begin
         m1_valid = v; m1_addr = addr; m1_wdata = wdata; m1_wstrb = wstrb;
      end else begin
         m0_valid = v; m0_addr = addr; m0_wdata = wdata; m0_wstrb = wstrb; m0_instr = 1'b0;
      end
   endtask

   task automatic run_access(input string tag, input vec_t v);
      int got = -1;
      logic [3:0]  s_mask = 4'hx;
      logic        s_rstrb = 1'bx;
      logic [31:0] s_addr = 32'hx, s_rdz = 32'hx, r_rdata = 32'hx;
      logic        r_oor = 1'bx, other = 1'b0;
      @(posedge clk); #1;
      drive(v.mst, 1'b1, v.addr, v.wdata, v.wstrb);
      for (int k = 0; k < 12 && got < 0; k++) begin
         @(negedge clk);
         if (k == 1) begin
            s_mask = mem_wmask; s_rstrb = mem_rstrb; s_addr = mem_addr;
            s_rdz = v.mst ? m1_rdata : m0_rdata;
         end
         if (v.mst ? m0_ready : m1_ready) other = 1'b1;
         if (v.mst ? m1_ready : m0_ready) begin
            got = k; r_rdata = v.mst ? m1_rdata : m0_rdata; r_oor = oor_err;
         end
         @(posedge clk); #1;
         if ((v.drop && k == 0) || got >= 0) drive(v.mst, 1'b0, v.addr, v.wdata, v.wstrb);
      end
      drive(v.mst, 1'b0, v.addr, v.wdata, v.wstrb);
      check({tag, " latency"}, got, v.exp_lat);
      check({tag, " rdata"}, r_rdata, v.exp_rdata);
      check({tag, " oor_err"}, {31'd0, r_oor}, {31'd0, v.exp_oor});
      check({tag, " wmask@S"}, {28'd0, s_mask}, {28'd0, v.exp_mask});
      check({tag, " rstrb@S"}, {31'd0, s_rstrb}, {31'd0, v.exp_rstrb});
      check({tag, " mem_addr@S"}, s_addr, v.addr);
      check({tag, " rdata0@S"}, s_rdz, 32'd0);
      check({tag, " other_ready"}, {31'd0, other}, 32'd0);
   endtask

   task automatic both_read(input logic [31:0] a0, input logic [31:0] a1,
                            output int t0, output int t1, output logic [31:0] d0, output logic [31:0] d1);
      t0 = -1; t1 = -1; d0 = 32'hx; d1 = 32'hx;
      @(posedge clk); #1;
      drive(1'b0, 1'b1, a0, 32'd0, 4'd0);
      drive(1'b1, 1'b1, a1, 32'd0, 4'd0);
      for (int k = 0; k < 20 && (t0 < 0 || t1 < 0); k++) begin
         @(negedge clk);
         if (m0_ready) begin t0 = k; d0 = m0_rdata; end
         if (m1_ready) begin t1 = k; d1 = m1_rdata; end
         @(posedge clk); #1;
         if (t0 >= 0) m0_valid = 1'b0;
         if (t1 >= 0) m1_valid = 1'b0;
      end
      m0_valid = 1'b0; m1_valid = 1'b0;
   endtask

   task automatic do_reset();
      @(posedge clk); #1;
      rst = 1'b1;
      m0_valid = 1'b0; m1_valid = 1'b0; b_m0_valid = 1'b0; b_m1_valid = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
   endtask

   initial begin
      int t0, t1, ng, widx, rdy_cnt, k_rstrb, k_rdy;
      logic [31:0] d0, d1, b_d;
      logic m1_done;
      int gt[16];
      logic gm[16];
      logic [31:0] wr_addr[3];
      logic [31:0] wr_data[3];
      vec_t solo;

      //              mst   addr            wdata          wstrb  drop  exp_rdata      oor   mask   rstrb lat
      vt[0]  = '{1'b0, 32'h0000_0010, 32'h0,         4'h0, 1'b0, 32'hC0DE_0004, 1'b0, 4'h0, 1'b1, 2};
      vt[1]  = '{1'b0, 32'h0000_0008, 32'hDEADBEEF,  4'h3, 1'b0, 32'h0,         1'b0, 4'h3, 1'b0, 2};
      vt[2]  = '{1'b0, 32'h0000_0008, 32'h0,         4'h0, 1'b0, 32'hC0DE_BEEF, 1'b0, 4'h0, 1'b1, 2};
      vt[3]  = '{1'b1, 32'h0000_0020, 32'h12345678,  4'hF, 1'b0, 32'h0,         1'b0, 4'hF, 1'b0, 2};
      vt[4]  = '{1'b1, 32'h0000_0020, 32'h0,         4'h0, 1'b0, 32'h12345678,  1'b0, 4'h0, 1'b1, 2};
      vt[5]  = '{1'b0, 32'h0000_1000, 32'h0,         4'h0, 1'b0, 32'h0,         1'b1, 4'h0, 1'b0, 2};
      vt[6]  = '{1'b1, 32'h0000_0FFC, 32'hAABBCCDD,  4'hC, 1'b0, 32'h0,         1'b0, 4'hC, 1'b0, 2};
      vt[7]  = '{1'b1, 32'h0000_0FFC, 32'h0,         4'h0, 1'b0, 32'hAABB_03FF, 1'b0, 4'h0, 1'b1, 2};
      vt[8]  = '{1'b0, 32'h0000_1004, 32'h11111111,  4'hF, 1'b0, 32'h0,         1'b1, 4'h0, 1'b0, 2};
      vt[9]  = '{1'b0, 32'h0000_0013, 32'h0,         4'h0, 1'b0, 32'hC0DE_0004, 1'b0, 4'h0, 1'b1, 2};
      vt[10] = '{1'b0, 32'h0000_0030, 32'hCAFEF00D,  4'hF, 1'b1, 32'h0,         1'b0, 4'hF, 1'b0, 2};
      vt[11] = '{1'b0, 32'h0000_0030, 32'h0,         4'h0, 1'b0, 32'hCAFEF00D,  1'b0, 4'h0, 1'b1, 2};
      vt[12] = '{1'b1, 32'hFFFF_FFFC, 32'h0,         4'h0, 1'b0, 32'h0,         1'b1, 4'h0, 1'b0, 2};

      rst = 1'b1; init_mem = 1'b1;
      m0_valid = 0; m0_instr = 0; m0_addr = 0; m0_wdata = 0; m0_wstrb = 0;
      m1_valid = 0; m1_addr = 0; m1_wdata = 0; m1_wstrb = 0;
      b_m0_valid = 0; b_m0_instr = 0; b_m0_addr = 0; b_m0_wdata = 0; b_m0_wstrb = 0;
      b_m1_valid = 0; b_m1_addr = 0; b_m1_wdata = 0; b_m1_wstrb = 0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("reset ready", {30'd0, m0_ready, m1_ready}, 32'd0);
      check("reset strobes", {27'd0, mem_wmask, mem_rstrb}, 32'd0);
      check("reset oor_err", {31'd0, oor_err}, 32'd0);
      check("reset mem_addr", mem_addr, 32'd0);
      check("reset mem_wdata", mem_wdata, 32'd0);
      check("reset rdata", m0_rdata | m1_rdata, 32'd0);
      @(posedge clk); #1;
      init_mem = 1'b0; rst = 1'b0;

      // Reset asserted while a read sits in STROBE: no ready may follow
      @(posedge clk); #1;
      drive(1'b0, 1'b1, 32'h10, 32'd0, 4'd0);
      @(negedge clk);
      @(posedge clk); #1;
      @(negedge clk);
      check("midreset rstrb@S", {31'd0, mem_rstrb}, 32'd1);
      rst = 1'b1;
      m0_valid = 1'b0;
      #1 check("midreset rstrb cleared", {31'd0, mem_rstrb}, 32'd0);
      rdy_cnt = 0;
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         if (m0_ready || m1_ready) rdy_cnt++;
         if (k == 2) begin @(posedge clk); #1 rst = 1'b0; end
      end
      check("midreset no ready", rdy_cnt, 0);

      for (int i = 0; i < 13; i++) run_access($sformatf("vec%0d", i), vt[i]);

      // Simultaneous reads; last grant before this point went to m1
      both_read(32'h40, 32'h44, t0, t1, d0, d1);
      check("pair1 m0 time", t0, 2);
      check("pair1 m1 time", t1, 5);
      check("pair1 m0 data", d0, 32'hC0DE_0010);
      check("pair1 m1 data", d1, 32'hC0DE_0011);
      solo = '{1'b0, 32'h48, 32'h0, 4'h0, 1'b0, 32'hC0DE_0012, 1'b0, 4'h0, 1'b1, 2};
      run_access("solo m0", solo);
      both_read(32'h40, 32'h44, t0, t1, d0, d1);
`ifdef MEM_ARB_RR_EN
      check("pair2 m1 time", t1, 2);
      check("pair2 m0 time", t0, 5);
`else
      check("pair2 m0 time", t0, 2);
      check("pair2 m1 time", t1, 5);
`endif
      check("pair2 m0 data", d0, 32'hC0DE_0010);
      check("pair2 m1 data", d1, 32'hC0DE_0011);

      // m0 read held continuously while m1 issues three writes
      do_reset();
      wr_addr[0] = 32'h100; wr_addr[1] = 32'h104; wr_addr[2] = 32'h108;
      wr_data[0] = 32'hA0A0_0001; wr_data[1] = 32'hA0A0_0002; wr_data[2] = 32'hA0A0_0003;
      @(posedge clk); #1;
      drive(1'b0, 1'b1, 32'h10, 32'd0, 4'd0);
      drive(1'b1, 1'b1, wr_addr[0], wr_data[0], 4'hF);
      widx = 0; ng = 0; m1_done = 1'b0; rdy_cnt = 0;
      for (int k = 0; k < 40 && ng < 6; k++) begin
         @(negedge clk);
         if (m0_ready && ng < 16) begin
            gm[ng] = 1'b0; gt[ng] = k; ng++;
            if (m0_rdata !== 32'hC0DE_0004) rdy_cnt++;
         end
         if (m1_ready && ng < 16) begin gm[ng] = 1'b1; gt[ng] = k; ng++; m1_done = 1'b1; end
         @(posedge clk); #1;
         if (m1_done) begin
            m1_done = 1'b0; widx++;
            if (widx < 3) drive(1'b1, 1'b1, wr_addr[widx], wr_data[widx], 4'hF);
            else m1_valid = 1'b0;
         end
      end
      m0_valid = 1'b0;
      check("held grant count", ng, 6);
      for (int i = 0; i < 6; i++) begin
`ifdef MEM_ARB_RR_EN
         check($sformatf("held grant%0d master", i), {31'd0, gm[i]}, 32'(i % 2));
`else
         check($sformatf("held grant%0d master", i), {31'd0, gm[i]}, 32'd0);
`endif
         check($sformatf("held grant%0d time", i), gt[i], 2 + 3 * i);
      end
      check("held m0 rdata errors", rdy_cnt, 0);
      for (int k = 0; k < 40 && widx < 3; k++) begin
         @(negedge clk);
         if (m1_ready) m1_done = 1'b1;
         @(posedge clk); #1;
         if (m1_done) begin
            m1_done = 1'b0; widx++;
            if (widx < 3) drive(1'b1, 1'b1, wr_addr[widx], wr_data[widx], 4'hF);
            else m1_valid = 1'b0;
         end
      end
      m1_valid = 1'b0;
      check("m1 writes done", widx, 3);
      solo = '{1'b1, 32'h108, 32'h0, 4'h0, 1'b0, 32'hA0A0_0003, 1'b0, 4'h0, 1'b1, 2};
      run_access("m1 readback", solo);

      // RD_LAT=3 instance: m1 read
      @(posedge clk); #1;
      b_m1_valid = 1'b1; b_m1_addr = 32'h18; b_m1_wdata = 32'd0; b_m1_wstrb = 4'd0;
      k_rstrb = -1; k_rdy = -1; b_d = 32'hx;
      for (int k = 0; k < 12 && k_rdy < 0; k++) begin
         @(negedge clk);
         if (b_mem_rstrb && k_rstrb < 0) k_rstrb = k;
         if (b_m1_ready) begin k_rdy = k; b_d = b_m1_rdata; end
         @(posedge clk); #1;
         if (k_rdy >= 0) b_m1_valid = 1'b0;
      end
      b_m1_valid = 1'b0;
      check("lat3 rstrb time", k_rstrb, 1);
      check("lat3 ready time", k_rdy, 4);
      check("lat3 rdata", b_d, 32'hC0DE_0006);

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule
